// File: rtl/snn_pkt_pkg.sv
// Shared packet definitions for the SNN accelerator fabric.
// Contents:
//    PKT_W, PSUM_W          packet and partial-sum payload widths
//    SRC_MSB/DEST_MSB/...   field offsets inside a packet
//    PKT_TYPE_*             packet type codes
//    make_psum_pkt()        builds {src, dest, type, 16'b0, psum}
package snn_pkt_pkg;

   localparam int PKT_W    = 34;
   localparam int PSUM_W   = 8;
   localparam int SRC_MSB  = 33;
   localparam int DEST_MSB = 29;
   localparam int TYPE_MSB = 25;

   localparam logic [1:0] PKT_TYPE_PSUM  = 2'b10;
   localparam logic [1:0] PKT_TYPE_SPIKE = 2'b01;

   function automatic logic [PKT_W-1:0] make_psum_pkt(
      input logic [3:0]        src,
      input logic [3:0]        dest,
      input logic [PSUM_W-1:0] psum
   );
      make_psum_pkt = {src, dest, PKT_TYPE_PSUM, 16'h0000, psum};
   endfunction

endpackage

// File: rtl/psum_packet_merger_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//    req      in   N       request vector
//    ptr      in   IDX_W   index searched first; search wraps upward
//    gnt      out  N       one-hot grant (all zero when no request)
//    gnt_idx  out  IDX_W   index of the granted requester
// The pointer register lives in the parent.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic             found_s;
   logic [IDX_W-1:0] cand_s;

   // First requester at or after ptr (with wrap) wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      cand_s  = '0;
      for (int k = 0; k < N; k++) begin
         cand_s = IDX_W'((int'(ptr) + k) % N);
         if (!found_s && req[cand_s]) begin
            gnt[cand_s] = 1'b1;
            gnt_idx     = cand_s;
            found_s     = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/psum_packet_merger.sv
// Merges one partial sum per PE per round into a serial psum packet stream,
// guaranteeing that a round carries exactly one packet from every PE.
// Ports:
//    clk, rst_n   clock (rising edge) and async active-low reset
//    pe_valid     per-PE sum valid
//    pe_ready     per-PE slot empty (registered)
//    pe_psum      PE i sum at [i*PSUM_W +: PSUM_W]
//    out_valid    out_packet valid
//    out_ready    downstream accepts
//    out_packet   {src, dest, 2'b10, 16'b0, psum}
//    round_done   one-cycle pulse together with the last packet of a round
//    round_cnt    completed rounds, wraps
module psum_packet_merger
   import snn_pkt_pkg::*;
#(
   parameter int         NUM_PE    = 3,
   parameter int         PSUM_W    = 8,
   parameter int         PKT_W     = 34,
   parameter logic [3:0] SRC_BASE  = 4'b1000,
   parameter logic [3:0] DEST_ADDR = 4'b0100
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_PE-1:0]        pe_valid,
   output logic [NUM_PE-1:0]        pe_ready,
   input  logic [NUM_PE*PSUM_W-1:0] pe_psum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PKT_W-1:0]         out_packet,
   output logic                     round_done,
   output logic [7:0]               round_cnt
);

   localparam int IDX_W = $clog2(NUM_PE);

   logic [NUM_PE-1:0] slot_full_r;
   logic [PSUM_W-1:0] slot_data_r [NUM_PE];
   logic [NUM_PE-1:0] sent_mask_r;
   logic [IDX_W-1:0]  rr_ptr_r;
   logic              out_valid_r;
   logic [PKT_W-1:0]  out_packet_r;
   logic              round_done_r;
   logic [7:0]        round_cnt_r;

   logic [NUM_PE-1:0] elig_s;
   logic [NUM_PE-1:0] gnt_s;
   logic [NUM_PE-1:0] take_s;
   logic [IDX_W-1:0]  gnt_idx_s;
   logic [IDX_W-1:0]  ptr_next_s;
   logic              load_s;
   logic              round_end_s;
   logic [PKT_W-1:0]  pkt_s;

   rr_arbiter #(.N(NUM_PE), .IDX_W(IDX_W)) u_arb (
      .req     (elig_s),
      .ptr     (rr_ptr_r),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // Eligibility, load decision, round completion and packet assembly.
   // A slot already sent this round is held back, which keeps early
   // next-round sums out of the current round.
   always_comb begin
      elig_s      = slot_full_r & ~sent_mask_r;
      take_s      = pe_valid & ~slot_full_r;
      load_s      = (~out_valid_r | out_ready) & (|elig_s);
      round_end_s = ((sent_mask_r | gnt_s) == {NUM_PE{1'b1}});
      if (gnt_idx_s == IDX_W'(NUM_PE - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = gnt_idx_s + IDX_W'(1);
      end
      pkt_s = make_psum_pkt(SRC_BASE + 4'(gnt_idx_s), DEST_ADDR,
                            slot_data_r[gnt_idx_s]);
   end

   // Input slots: capture on transfer, empty on grant. A granted slot was
   // full, so its ready was low and it cannot refill in the grant cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full_r <= '0;
         for (int i = 0; i < NUM_PE; i++) begin
            slot_data_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PE; i++) begin
            if (load_s && gnt_s[i]) begin
               slot_full_r[i] <= 1'b0;
            end else if (take_s[i]) begin
               slot_full_r[i] <= 1'b1;
               slot_data_r[i] <= pe_psum[i*PSUM_W +: PSUM_W];
            end else begin
               slot_full_r[i] <= slot_full_r[i];
            end
         end
      end
   end

   // Output register, round bookkeeping and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         out_packet_r <= '0;
         round_done_r <= 1'b0;
         round_cnt_r  <= 8'd0;
         sent_mask_r  <= '0;
         rr_ptr_r     <= '0;
      end else begin
         round_done_r <= 1'b0;
         if (load_s) begin
            out_valid_r  <= 1'b1;
            out_packet_r <= pkt_s;
            rr_ptr_r     <= ptr_next_s;
            if (round_end_s) begin
               // Final grant of the round: mask clears rather than taking the bit.
               sent_mask_r  <= '0;
               round_done_r <= 1'b1;
               round_cnt_r  <= round_cnt_r + 8'd1;
            end else begin
               sent_mask_r <= sent_mask_r | gnt_s;
            end
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign pe_ready   = ~slot_full_r;
   assign out_valid  = out_valid_r;
   assign out_packet = out_packet_r;
   assign round_done = round_done_r;
   assign round_cnt  = round_cnt_r;

endmodule

// File: tb/tb_psum_packet_merger.sv
// Directed self-checking bench for psum_packet_merger (NUM_PE=3).
module tb_psum_packet_merger;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [2:0]  pe_valid = 3'b000;
   logic [2:0]  pe_ready;
   logic [23:0] pe_psum = 24'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [33:0] out_packet;
   logic        round_done;
   logic [7:0]  round_cnt;

   int chk_cnt = 0;
   int err_cnt = 0;

   psum_packet_merger dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pe_valid   (pe_valid),
      .pe_ready   (pe_ready),
      .pe_psum    (pe_psum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_packet (out_packet),
      .round_done (round_done),
      .round_cnt  (round_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] exp_pkt(input logic [3:0] src, input logic [7:0] psum);
      exp_pkt = {src, 4'b0100, 2'b10, 16'h0000, psum};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] v, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
      pe_valid = v;
      pe_psum  = {p2, p1, p0};
      tick();
      pe_valid = 3'b000;
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [33:0] held_pkt;
   int          exp_idx;
   int          pkts;
   int          dones;

   initial begin
      // 1: reset
      #3 rst_n = 1'b0;
      #1;
      check_eq("rst_pe_ready",   pe_ready,   3'b111);
      check_eq("rst_out_valid",  out_valid,  1'b0);
      check_eq("rst_out_packet", out_packet, 34'h0);
      check_eq("rst_round_done", round_done, 1'b0);
      check_eq("rst_round_cnt",  round_cnt,  8'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // 2: all three PEs at once, three consecutive packets
      send(3'b111, 8'd10, 8'd5, 8'd1);
      check_eq("t2_ready_low", pe_ready,  3'b000);
      check_eq("t2_no_valid",  out_valid, 1'b0);
      tick();
      check_eq("t2_v0",   out_valid,  1'b1);
      check_eq("t2_pkt0", out_packet, 34'b1000_0100_10_0000000000000000_00001010);
      check_eq("t2_rd0",  round_done, 1'b0);
      tick();
      check_eq("t2_pkt1", out_packet, 34'b1001_0100_10_0000000000000000_00000101);
      check_eq("t2_rd1",  round_done, 1'b0);
      tick();
      check_eq("t2_pkt2", out_packet, 34'b1010_0100_10_0000000000000000_00000001);
      check_eq("t2_rd2",  round_done, 1'b1);
      check_eq("t2_cnt",  round_cnt,  8'd1);
      tick();
      check_eq("t2_idle", out_valid,  1'b0);
      check_eq("t2_rdlo", round_done, 1'b0);

      // 3: PE0 submits twice; second sum waits for the next round
      send(3'b001, 8'd7, 8'd0, 8'd0);
      tick();
      check_eq("t3_pkt7", out_packet, exp_pkt(4'b1000, 8'd7));
      send(3'b001, 8'd9, 8'd0, 8'd0);
      check_eq("t3_held_ready", pe_ready[0], 1'b0);
      tick();
      tick();
      tick();
      check_eq("t3_not_sent", out_valid,   1'b0);
      check_eq("t3_still_held", pe_ready[0], 1'b0);
      send(3'b110, 8'd0, 8'd20, 8'd30);
      tick();
      check_eq("t3_pe1", out_packet, exp_pkt(4'b1001, 8'd20));
      tick();
      check_eq("t3_pe2",  out_packet, exp_pkt(4'b1010, 8'd30));
      check_eq("t3_rd",   round_done, 1'b1);
      check_eq("t3_cnt",  round_cnt,  8'd2);
      tick();
      check_eq("t3_v9",   out_valid,  1'b1);
      check_eq("t3_pkt9", out_packet, exp_pkt(4'b1000, 8'd9));
      check_eq("t3_rd9",  round_done, 1'b0);
      tick();
      check_eq("t3_idle", out_valid, 1'b0);

      // 4: stall for 5 cycles with a packet loaded
      out_ready = 1'b0;
      send(3'b010, 8'd0, 8'h33, 8'd0);
      tick();
      held_pkt = exp_pkt(4'b1001, 8'h33);
      pe_valid = 3'b100;
      pe_psum  = {8'h44, 16'h0};
      for (int k = 0; k < 5; k++) begin
         check_eq("t4_hold_v",   out_valid,  1'b1);
         check_eq("t4_hold_pkt", out_packet, held_pkt);
         tick();
         pe_valid = 3'b000;
      end
      out_ready = 1'b1;
      tick();
      check_eq("t4_next", out_packet, exp_pkt(4'b1010, 8'h44));
      check_eq("t4_rd",   round_done, 1'b1);
      check_eq("t4_cnt",  round_cnt,  8'd3);
      tick();
      check_eq("t4_nodup", out_valid, 1'b0);

      // 5: reset after two of three packets
      send(3'b111, 8'h11, 8'h22, 8'h33);
      tick();
      check_eq("t5_p0", out_packet, exp_pkt(4'b1000, 8'h11));
      tick();
      check_eq("t5_p1", out_packet, exp_pkt(4'b1001, 8'h22));
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_v",     out_valid,  1'b0);
      check_eq("t5_rst_pkt",   out_packet, 34'h0);
      check_eq("t5_rst_ready", pe_ready,   3'b111);
      check_eq("t5_rst_cnt",   round_cnt,  8'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("t5_no_leftover", out_valid, 1'b0);
      send(3'b100, 8'd0, 8'd0, 8'h55);
      tick();
      check_eq("t5_pe2",    out_packet, exp_pkt(4'b1010, 8'h55));
      check_eq("t5_pe2_rd", round_done, 1'b0);
      tick();
      check_eq("t5_idle",   out_valid,  1'b0);
      check_eq("t5_cnt0",   round_cnt,  8'd0);
      send(3'b011, 8'h01, 8'h02, 8'd0);
      tick();
      check_eq("t5_pe0",    out_packet, exp_pkt(4'b1000, 8'h01));
      check_eq("t5_pe0_rd", round_done, 1'b0);
      tick();
      check_eq("t5_pe1",    out_packet, exp_pkt(4'b1001, 8'h02));
      check_eq("t5_pe1_rd", round_done, 1'b1);
      check_eq("t5_cnt1",   round_cnt,  8'd1);

      // 6: 256 rounds under continuous load
      do_reset();
      pe_valid = 3'b111;
      pe_psum  = {8'h63, 8'h62, 8'h61};
      exp_idx  = 0;
      pkts     = 0;
      dones    = 0;
      for (int c = 0; c < 3000 && pkts < 768; c++) begin
         tick();
         if (round_done) dones++;
         if (out_valid) begin
            check_eq("t6_pkt", out_packet, exp_pkt(4'(8 + exp_idx), 8'(8'h61 + exp_idx)));
            check_eq("t6_rd",  round_done, (exp_idx == 2) ? 1'b1 : 1'b0);
            exp_idx = (exp_idx + 1) % 3;
            pkts++;
         end
      end
      pe_valid = 3'b000;
      check_eq("t6_pkts", pkts,      768);
      check_eq("t6_done", dones,     256);
      check_eq("t6_wrap", round_cnt, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
